// File: rtl/boot_seq_loader.sv
// boot_seq_loader: Wishbone classic master that drives a boot DMA controller to copy NUM_BLOCKS blocks
// Ports: CLK_I/RST_I clock and synchronous active-high reset; CYC_O/STB_O/WE_O/ADR_O/DAT_O/SEL_O
// registered Wishbone request; DAT_I/ACK_I/ERR_I/RTY_I slave response; loading_finished_o high once
// every block is copied; error_o sticky failure flag; block_cnt_o blocks completed so far.
// Build option BOOT_SEQ_RETRY_EN: retry RTY_I/ERR_I after 16 idle cycles (up to 3 times per
// transaction) and expose retry_cnt_o; without it any RTY_I/ERR_I is fatal.
module boot_seq_loader #(
  parameter logic [29:0] CTRL_BASE  = 30'h3000_0000,
  parameter int          NUM_BLOCKS = 4,
  parameter int          BLOCK_SIZE = 2048,
  parameter logic [31:0] DEST_BASE  = 32'h0000_0000,
  parameter int          POLL_WAIT  = 1024,
  parameter int          MAX_POLLS  = 0,
  parameter logic [31:0] STATUS_OK  = 32'd2,
  parameter logic [31:0] CTRL_START = 32'd2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [29:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I,
  input  logic        ERR_I,
  input  logic        RTY_I,
  output logic        loading_finished_o,
  output logic        error_o,
  output logic [7:0]  block_cnt_o
`ifdef BOOT_SEQ_RETRY_EN
  ,
  output logic [1:0]  retry_cnt_o
`endif
);
  localparam int WW = $clog2(POLL_WAIT + 1);
  localparam int PW = $clog2(MAX_POLLS + 2);
  typedef enum logic [3:0] {
    POLL_RDY, WAIT_RDY, SET_DEST, SET_SIZE, START, POLL_DONE, WAIT_DONE, NEXT, FINISHED, ERROR
  } state_t;
  state_t state_q, state_d;
  logic cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d, dest;
  logic [WW-1:0] wait_q, wait_d;
  logic [PW-1:0] poll_q, poll_d;
  // one bit wider than block_cnt_o so NUM_BLOCKS=256 can be reached
  logic [8:0] cnt_q, cnt_d;
  logic bus_st, issue, poll_ok, poll_lim;
`ifdef BOOT_SEQ_RETRY_EN
  logic [4:0] rw_q, rw_d;
  logic [1:0] retry_q, retry_d;
  assign retry_cnt_o = retry_q;
`endif
  assign dest = DEST_BASE + 32'(BLOCK_SIZE) * {23'd0, cnt_q};
  always_comb begin
    state_d = state_q;
    cyc_d = cyc_q;
    stb_d = stb_q;
    we_d = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    wait_d = wait_q;
    poll_d = poll_q;
    cnt_d = cnt_q;
`ifdef BOOT_SEQ_RETRY_EN
    rw_d = rw_q;
    retry_d = retry_q;
`endif
    issue = 1'b0;
    bus_st = state_q inside {POLL_RDY, SET_DEST, SET_SIZE, START, POLL_DONE};
    poll_ok = DAT_I == STATUS_OK;
    poll_lim = MAX_POLLS != 0 && int'(poll_q) + 1 >= MAX_POLLS;
    if (bus_st && stb_q && (ACK_I || ERR_I || RTY_I)) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
      if (ERR_I || RTY_I) begin
`ifdef BOOT_SEQ_RETRY_EN
        if (retry_q == 2'd3) state_d = ERROR;
        else begin
          retry_d = retry_q + 2'd1;
          rw_d = 5'd16;
        end
`else
        state_d = ERROR;
`endif
      end else begin
`ifdef BOOT_SEQ_RETRY_EN
        retry_d = 2'd0;
`endif
        case (state_q)
          POLL_RDY, POLL_DONE:
            if (poll_ok) state_d = state_q == POLL_RDY ? SET_DEST : NEXT;
            else begin
              poll_d = MAX_POLLS != 0 ? poll_q + PW'(1) : poll_q;
              state_d = poll_lim ? ERROR : state_q == POLL_RDY ? WAIT_RDY : WAIT_DONE;
            end
          SET_DEST: state_d = SET_SIZE;
          SET_SIZE: state_d = START;
          default: begin
            state_d = POLL_DONE;
            poll_d = '0;
          end
        endcase
      end
    end else if (bus_st && !stb_q) begin
`ifdef BOOT_SEQ_RETRY_EN
      // a pending retry holds the bus idle; the reissue fires on its last idle cycle
      rw_d = rw_q == 5'd0 ? 5'd0 : rw_q - 5'd1;
      issue = rw_q <= 5'd1;
`else
      issue = 1'b1;
`endif
    end else if (state_q == WAIT_RDY || state_q == WAIT_DONE) begin
      wait_d = wait_q + WW'(1);
      // reissuing from the last wait cycle keeps the idle gap at exactly POLL_WAIT
      if (wait_q == WW'(POLL_WAIT - 1)) begin
        wait_d = '0;
        state_d = state_q == WAIT_RDY ? POLL_RDY : POLL_DONE;
        issue = 1'b1;
      end
    end else if (state_q == NEXT) begin
      cnt_d = cnt_q + 9'd1;
      poll_d = '0;
      state_d = int'(cnt_q) + 1 == NUM_BLOCKS ? FINISHED : POLL_RDY;
    end
    if (issue) begin
      cyc_d = 1'b1;
      stb_d = 1'b1;
      we_d = state_d inside {SET_DEST, SET_SIZE, START};
      adr_d = CTRL_BASE + (state_d == SET_DEST ? 30'd1 : state_d == SET_SIZE ? 30'd2 :
                           state_d == START ? 30'd3 : 30'd0);
      dat_d = state_d == SET_DEST ? dest : state_d == SET_SIZE ? 32'(BLOCK_SIZE) :
              state_d == START ? CTRL_START : 32'd0;
    end
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= POLL_RDY;
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      wait_q <= '0;
      poll_q <= '0;
      cnt_q <= '0;
`ifdef BOOT_SEQ_RETRY_EN
      rw_q <= '0;
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      stb_q <= stb_d;
      we_q <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      wait_q <= wait_d;
      poll_q <= poll_d;
      cnt_q <= cnt_d;
`ifdef BOOT_SEQ_RETRY_EN
      rw_q <= rw_d;
      retry_q <= retry_d;
`endif
    end
  end
  assign CYC_O = cyc_q;
  assign STB_O = stb_q;
  assign WE_O = we_q;
  assign ADR_O = adr_q;
  assign DAT_O = dat_q;
  assign SEL_O = 4'hF;
  assign loading_finished_o = state_q == FINISHED;
  assign error_o = state_q == ERROR;
  assign block_cnt_o = cnt_q[7:0];
endmodule

// File: tb/tb_boot_seq_loader.sv
// tb_boot_seq_loader: randomized Wishbone slave plus transaction-level model for boot_seq_loader
module tb_boot_seq_loader;
  localparam int NB = 2;
  localparam int PWAIT = 8;
  localparam int MAXP = 3;
  localparam logic [29:0] CB = 30'h3000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc_o, stb_o, we_o, finished, error;
  logic [29:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i = '0;
  logic [3:0] sel_o;
  logic ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
  logic [7:0] blk;
`ifdef BOOT_SEQ_RETRY_EN
  logic [1:0] retry_cnt;
`endif
  always #5 clk = ~clk;
  boot_seq_loader #(.NUM_BLOCKS(NB), .POLL_WAIT(PWAIT), .MAX_POLLS(MAXP)) dut (
    .CLK_I(clk), .RST_I(rst), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .ADR_O(adr_o),
    .DAT_O(dat_o), .SEL_O(sel_o), .DAT_I(dat_i), .ACK_I(ack_i), .ERR_I(err_i), .RTY_I(rty_i),
    .loading_finished_o(finished), .error_o(error), .block_cnt_o(blk)
`ifdef BOOT_SEQ_RETRY_EN
    , .retry_cnt_o(retry_cnt)
`endif
  );
  typedef struct {
    logic        we;
    logic [29:0] adr;
    logic [31:0] dat;
    int          kind;
    int          st;
    int          fin;
    bit          stable;
  } tx_t;
  tx_t log_q[$];
  tx_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int rf_cfg, df_cfg, max_delay, fixed_delay, err_idx, rty_idx, rty_cnt;
  bit noise;
  bit in_tx;
  int tw, cur_d, acked, rty_done, phase, left;
  tx_t cur;
  initial forever begin
    @(posedge clk);
    cyc_n++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  // slave + monitor: kind 0=ACK 1=ERR 2=RTY
  initial forever begin
    @(negedge clk);
    ack_i = 1'b0;
    err_i = 1'b0;
    rty_i = 1'b0;
    dat_i = $urandom;
    if (stb_o) begin
      if (!in_tx) begin
        in_tx = 1'b1;
        tw = 0;
        cur_d = fixed_delay >= 0 ? fixed_delay : int'($urandom_range(max_delay));
        cur = '{we_o, adr_o, dat_o, 0, cyc_n, 0, 1'b1};
      end
      if (we_o !== cur.we || adr_o !== cur.adr || dat_o !== cur.dat || cyc_o !== 1'b1) cur.stable = 1'b0;
      if (tw == cur_d) begin
        if (acked == err_idx) begin
          err_i = 1'b1;
          cur.kind = 1;
        end else if (acked == rty_idx && rty_done < rty_cnt) begin
          rty_i = 1'b1;
          cur.kind = 2;
          rty_done++;
        end else begin
          ack_i = 1'b1;
          acked++;
          if (!cur.we && cur.adr == CB) begin
            if (left > 0) begin
              left--;
              if (dat_i == 32'd2) dat_i = 32'd3;
            end else begin
              dat_i = 32'd2;
              if (phase == 1) begin
                phase = 0;
                left = rf_cfg;
              end
            end
          end
          if (cur.we && cur.adr == CB + 30'd3) begin
            phase = 1;
            left = df_cfg;
          end
        end
        cur.fin = cyc_n;
        log_q.push_back(cur);
        in_tx = 1'b0;
      end else tw++;
    end else begin
      in_tx = 1'b0;
      ack_i = noise && $urandom_range(3) == 0;
      err_i = noise && $urandom_range(5) == 0;
      rty_i = noise && $urandom_range(5) == 0;
    end
  end
  function automatic tx_t mk(input logic we, input logic [29:0] adr, input logic [31:0] dat);
    tx_t t = '{we, adr, dat, 0, 0, 0, 1'b1};
    return t;
  endfunction
  // reference sequence: rf failed ready polls and df failed done polls per block
  task automatic build(input int rf, input int df);
    exp_q.delete();
    for (int k = 0; k < NB; k++) begin
      repeat (rf + 1) exp_q.push_back(mk(1'b0, CB, 32'd0));
      exp_q.push_back(mk(1'b1, CB + 30'd1, 32'(k * 2048)));
      exp_q.push_back(mk(1'b1, CB + 30'd2, 32'd2048));
      exp_q.push_back(mk(1'b1, CB + 30'd3, 32'd2));
      repeat (df + 1) exp_q.push_back(mk(1'b0, CB, 32'd0));
    end
  endtask
  function automatic int first_diff();
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      if (log_q[i].we !== exp_q[i].we || log_q[i].adr !== exp_q[i].adr ||
          log_q[i].dat !== exp_q[i].dat || log_q[i].kind != exp_q[i].kind) return i;
    return log_q.size() == exp_q.size() ? -1 : (log_q.size() < exp_q.size() ? log_q.size() : exp_q.size());
  endfunction
  function automatic string desc(input int d);
    string g, e;
    g = d < log_q.size() ? $sformatf("we=%0b adr=%h dat=%h k=%0d", log_q[d].we, log_q[d].adr, log_q[d].dat, log_q[d].kind) : "none";
    e = d < exp_q.size() ? $sformatf("we=%0b adr=%h dat=%h k=%0d", exp_q[d].we, exp_q[d].adr, exp_q[d].dat, exp_q[d].kind) : "none";
    return $sformatf("at #%0d got {%s} n=%0d, expected {%s} n=%0d", d, g, log_q.size(), e, exp_q.size());
  endfunction
  // counts unstable requests, wrong lengths (when exact_len>=0) and gaps below one idle cycle
  function automatic int bad_timing(input int exact_len);
    int n = 0;
    foreach (log_q[i]) begin
      if (!log_q[i].stable) n++;
      if (exact_len >= 0 && log_q[i].fin - log_q[i].st != exact_len) n++;
      if (i > 0 && log_q[i].st - log_q[i-1].fin < 2) n++;
    end
    return n;
  endfunction
  task automatic cfg(input int rf, input int df, input int md, input int fd, input bit nz);
    rf_cfg = rf;
    df_cfg = df;
    max_delay = md;
    fixed_delay = fd;
    noise = nz;
    err_idx = -1;
    rty_idx = -1;
    rty_cnt = 0;
  endtask
  task automatic slave_init();
    in_tx = 1'b0;
    acked = 0;
    rty_done = 0;
    phase = 0;
    left = rf_cfg;
    log_q.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    slave_init();
    rst = 1'b0;
  endtask
  task automatic run_wait(output bit to);
    int n = 0;
    while (!(finished || error) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    to = !(finished || error);
  endtask
  task automatic test_reset();
    cfg(0, 0, 2, -1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cyc_o, stb_o, we_o, adr_o, dat_o, blk, finished, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b adr=%h dat=%h blk=%0d fin=%b err=%b, expected all 0",
               cyc_o, stb_o, we_o, adr_o, dat_o, blk, finished, error);
    end
    checks++;
    if (sel_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_sel: got %h expected f", sel_o);
    end
    slave_init();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (!(stb_o === 1'b1 && cyc_o === 1'b1 && we_o === 1'b0 && adr_o === CB && dat_o === 32'd0)) begin
      errors++;
      $display("FAIL first_strobe: got cyc=%b stb=%b we=%b adr=%h dat=%h, expected 1 1 0 %h 0", cyc_o, stb_o, we_o, adr_o, dat_o, CB);
    end
  endtask
  task automatic test_nominal();
    bit to;
    int d, n;
    cfg(0, 0, 3, -1, 1'b1);
    build(0, 0);
    do_reset();
    run_wait(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL nominal_timeout: no terminal state within budget");
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL nominal_seq: %s", desc(d));
    end
    checks++;
    if (!(finished === 1'b1 && error === 1'b0 && blk === 8'(NB) && cyc_o === 1'b0)) begin
      errors++;
      $display("FAIL nominal_end: got fin=%b err=%b blk=%0d cyc=%b, expected 1 0 %0d 0", finished, error, blk, cyc_o, NB);
    end
    checks++;
    if (bad_timing(-1) != 0) begin
      errors++;
      $display("FAIL nominal_timing: got %0d violations expected 0", bad_timing(-1));
    end
    n = log_q.size();
    repeat (40) @(negedge clk);
    checks++;
    if (log_q.size() != n || stb_o !== 1'b0) begin
      errors++;
      $display("FAIL nominal_quiet: got %0d transactions stb=%b after finish, expected %0d stb=0", log_q.size(), stb_o, n);
    end
  endtask
  task automatic test_poll_wait();
    bit to;
    int d;
    cfg(1, 0, 2, -1, 1'b1);
    build(1, 0);
    do_reset();
    run_wait(to);
    d = first_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL pollwait_seq: timeout=%b %s", to, desc(d));
    end
    checks++;
    if (log_q[1].st - log_q[0].fin - 1 != PWAIT) begin
      errors++;
      $display("FAIL pollwait_gap0: got %0d idle cycles expected %0d", log_q[1].st - log_q[0].fin - 1, PWAIT);
    end
    checks++;
    if (log_q[7].st - log_q[6].fin - 1 != PWAIT) begin
      errors++;
      $display("FAIL pollwait_gap1: got %0d idle cycles expected %0d", log_q[7].st - log_q[6].fin - 1, PWAIT);
    end
  endtask
  task automatic test_poll_timeout();
    bit to;
    int d;
    cfg(0, 1000, 2, -1, 1'b1);
    build(0, MAXP);
    while (exp_q.size() > 4 + MAXP) void'(exp_q.pop_back());
    do_reset();
    run_wait(to);
    repeat (30) @(negedge clk);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL timeout_seq: %s", desc(d));
    end
    checks++;
    if (!(error === 1'b1 && finished === 1'b0 && cyc_o === 1'b0 && stb_o === 1'b0 && blk === 8'd0)) begin
      errors++;
      $display("FAIL timeout_state: got err=%b fin=%b cyc=%b stb=%b blk=%0d, expected 1 0 0 0 0", error, finished, cyc_o, stb_o, blk);
    end
  endtask
`ifdef BOOT_SEQ_RETRY_EN
  task automatic test_bus_err();
    bit to;
    int d;
    tx_t t;
    cfg(0, 0, 2, -1, 1'b0);
    rty_idx = 7;
    rty_cnt = 2;
    build(0, 0);
    t = exp_q[7];
    t.kind = 2;
    exp_q.insert(7, t);
    exp_q.insert(7, t);
    do_reset();
    run_wait(to);
    d = first_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL retry_seq: timeout=%b %s", to, desc(d));
    end
    checks++;
    if (log_q[8].st - log_q[7].fin - 1 != 16 || log_q[9].st - log_q[8].fin - 1 != 16) begin
      errors++;
      $display("FAIL retry_gap: got %0d and %0d idle cycles expected 16 and 16",
               log_q[8].st - log_q[7].fin - 1, log_q[9].st - log_q[8].fin - 1);
    end
    checks++;
    if (!(finished === 1'b1 && retry_cnt === 2'd0 && blk === 8'(NB))) begin
      errors++;
      $display("FAIL retry_end: got fin=%b retry=%0d blk=%0d expected 1 0 %0d", finished, retry_cnt, blk, NB);
    end
  endtask
  task automatic test_retry_limit();
    bit to;
    int d;
    cfg(0, 0, 1, -1, 1'b0);
    err_idx = 7;
    build(0, 0);
    while (exp_q.size() > 8) void'(exp_q.pop_back());
    exp_q[7].kind = 1;
    repeat (3) exp_q.push_back(exp_q[7]);
    do_reset();
    run_wait(to);
    d = first_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL retrylim_seq: timeout=%b %s", to, desc(d));
    end
    checks++;
    if (!(error === 1'b1 && cyc_o === 1'b0 && blk === 8'd1)) begin
      errors++;
      $display("FAIL retrylim_state: got err=%b cyc=%b blk=%0d expected 1 0 1", error, cyc_o, blk);
    end
  endtask
`else
  task automatic test_bus_err();
    bit to;
    int d;
    cfg(0, 0, 2, -1, 1'b1);
    err_idx = 7;
    build(0, 0);
    while (exp_q.size() > 8) void'(exp_q.pop_back());
    exp_q[7].kind = 1;
    do_reset();
    run_wait(to);
    checks++;
    if (to || cyc_n - log_q[$].fin != 1) begin
      errors++;
      $display("FAIL buserr_latency: timeout=%b got %0d cycles to error expected 1", to, cyc_n - log_q[$].fin);
    end
    checks++;
    if (!(error === 1'b1 && cyc_o === 1'b0 && stb_o === 1'b0 && blk === 8'd1 && finished === 1'b0)) begin
      errors++;
      $display("FAIL buserr_state: got err=%b cyc=%b stb=%b blk=%0d fin=%b expected 1 0 0 1 0", error, cyc_o, stb_o, blk, finished);
    end
    repeat (20) @(negedge clk);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL buserr_seq: %s", desc(d));
    end
  endtask
`endif
  task automatic test_ack_delay();
    bit to;
    int d;
    cfg(0, 0, 0, 5, 1'b1);
    build(0, 0);
    do_reset();
    run_wait(to);
    d = first_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL delay_seq: timeout=%b %s", to, desc(d));
    end
    checks++;
    if (bad_timing(5) != 0) begin
      errors++;
      $display("FAIL delay_hold: got %0d violations expected 0", bad_timing(5));
    end
  endtask
  task automatic test_reset_mid();
    bit to;
    int d, n;
    cfg(0, 0, 0, 4, 1'b0);
    build(0, 0);
    do_reset();
    n = 0;
    while (!(stb_o && we_o && adr_o == CB + 30'd1 && blk == 8'd1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL midreset_reach: block 1 DEST write never seen");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cyc_o, stb_o, we_o, adr_o, dat_o, blk, finished, error} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got cyc=%b stb=%b we=%b adr=%h dat=%h blk=%0d, expected all 0", cyc_o, stb_o, we_o, adr_o, dat_o, blk);
    end
    slave_init();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (!(stb_o === 1'b1 && adr_o === CB && blk === 8'd0)) begin
      errors++;
      $display("FAIL midreset_restart: got stb=%b adr=%h blk=%0d expected 1 %h 0", stb_o, adr_o, blk, CB);
    end
    run_wait(to);
    d = first_diff();
    checks++;
    if (to || d != -1 || blk !== 8'(NB)) begin
      errors++;
      $display("FAIL midreset_seq: timeout=%b blk=%0d %s", to, blk, desc(d));
    end
  endtask
  task automatic test_random();
    bit to;
    int d, rf, df;
    for (int i = 0; i < 4; i++) begin
      rf = $urandom_range(2);
      df = $urandom_range(2);
      cfg(rf, df, $urandom_range(4), -1, 1'($urandom_range(1)));
      build(rf, df);
      do_reset();
      run_wait(to);
      d = first_diff();
      checks++;
      if (to || d != -1) begin
        errors++;
        $display("FAIL random_seq rf=%0d df=%0d: timeout=%b %s", rf, df, to, desc(d));
      end
      checks++;
      if (!(finished === 1'b1 && error === 1'b0 && blk === 8'(NB)) || bad_timing(-1) != 0) begin
        errors++;
        $display("FAIL random_end: got fin=%b err=%b blk=%0d violations=%0d expected 1 0 %0d 0", finished, error, blk, bad_timing(-1), NB);
      end
    end
  endtask
  initial begin
    cfg(0, 0, 0, -1, 1'b0);
    slave_init();
    test_reset();
    test_nominal();
    test_poll_wait();
    test_poll_timeout();
    test_bus_err();
`ifdef BOOT_SEQ_RETRY_EN
    test_retry_limit();
`endif
    test_ack_delay();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/boot_seq_loader.md
Name: boot_seq_loader

Overview:
Parametrised successor to the fixed single-shot boot loader. A Wishbone classic master that programs a boot-storage DMA controller to copy NUM_BLOCKS blocks into memory, one block at a time. For each block it polls ready, writes destination address, size and start, then polls completion. It adds poll timeouts, bus-error handling and progress reporting, and raises loading_finished_o once every block has been copied.

Parameters:
CTRL_BASE, 30'h3000_0000, word address of the controller: STATUS=+0, DEST=+1, SIZE=+2, CONTROL=+3
NUM_BLOCKS, 4, number of blocks to load (1..256)
BLOCK_SIZE, 2048, bytes per block; value written to SIZE
DEST_BASE, 32'h0000_0000, byte address of block 0
POLL_WAIT, 1024, idle cycles between status polls (>=1)
MAX_POLLS, 0, failed polls allowed per phase before error; 0 means unlimited
STATUS_OK, 32'd2, STATUS value meaning both idle/ready and done
CTRL_START, 32'd2, CONTROL write value that starts a copy

Ports:
CLK_I  in  1  clock
RST_I  in  1  reset; synchronous, active-high
CYC_O  out  1  Wishbone cycle
STB_O  out  1  Wishbone strobe
WE_O  out  1  write enable
ADR_O  out  30  word address [31:2]
DAT_O  out  32  write data
SEL_O  out  4  byte select; constant 4'hF
DAT_I  in  32  read data
ACK_I  in  1  acknowledge
ERR_I  in  1  bus error
RTY_I  in  1  retry
loading_finished_o  out  1  high in FINISHED
error_o  out  1  sticky error, high in ERROR
block_cnt_o  out  8  blocks completed so far

Behaviour:
- Reset: CYC_O, STB_O and WE_O are 0; ADR_O, DAT_O and block_cnt_o are 0; loading_finished_o and error_o are 0; wait and poll counters are 0; state is POLL_RDY. Reset asserted mid-transaction drops CYC_O and STB_O on the next edge.
- All bus outputs are registered. The first strobe appears at the first edge after RST_I deasserts.
- Transaction rule:
  - CYC_O and STB_O rise together with stable WE_O, ADR_O and DAT_O.
  - They are held unchanged until the cycle in which ACK_I, ERR_I or RTY_I is sampled high.
  - They deassert on the next edge, giving at least 1 idle cycle between transactions.
  - Priority is ERR_I, then RTY_I, then ACK_I.
- Reads drive DAT_O=0 and WE_O=0.
- State sequence per block k (0-based):
  - POLL_RDY: read STATUS. On ACK with DAT_I==STATUS_OK, go to SET_DEST. Otherwise go to WAIT_RDY.
  - WAIT_RDY: bus idle for POLL_WAIT cycles, then return to POLL_RDY.
  - SET_DEST: write DEST = DEST_BASE + k*BLOCK_SIZE, computed modulo 2^32 (wraps, no saturation).
  - SET_SIZE: write SIZE = BLOCK_SIZE.
  - START: write CONTROL = CTRL_START.
  - POLL_DONE / WAIT_DONE: same polling as the ready phase, but a successful read goes to NEXT.
  - NEXT: takes 1 cycle with the bus idle; block_cnt_o increments. If block_cnt_o now equals NUM_BLOCKS, go to FINISHED; otherwise go to POLL_RDY.
  - FINISHED: terminal; bus idle; loading_finished_o=1.
  - ERROR: terminal; bus idle; error_o=1. Only reset exits either terminal state.
- Poll limit: the poll counter clears on entry to each poll phase. Each unsuccessful poll increments it. With MAX_POLLS!=0, reaching MAX_POLLS unsuccessful polls goes to ERROR instead of WAIT.
- Wait counter: counts 0..POLL_WAIT-1 and clears on exit. Its width is clog2(POLL_WAIT+1).
- ERR_I on any transaction goes to ERROR.
- RTY_I without the optional feature is treated as ERR_I.
- A response seen while STB_O=0 is ignored.
- Invariants:
  - STB_O implies CYC_O.
  - loading_finished_o and error_o are never both 1.
  - block_cnt_o never exceeds NUM_BLOCKS.

Optional Feature:
BOOT_SEQ_RETRY_EN:
- Defined: RTY_I or ERR_I on a transaction deasserts the bus, waits 16 idle cycles, then reissues the identical transaction (same ADR_O, DAT_O and WE_O).
  - Retries are counted per transaction. The count clears on ACK_I.
  - A 4th consecutive failure goes to ERROR.
  - retry_cnt_o (out, 2 bits) reports the count.
- Undefined: RTY_I and ERR_I go to ERROR immediately, and the retry_cnt_o port is absent.

Test Plan:
1. NUM_BLOCKS=2, slave ACKs every cycle and STATUS always returns 2 -> exact sequence per block: read @3000_0000, write @3000_0001 (0x0 then 0x800), write @3000_0002=2048, write @3000_0003=2. loading_finished_o=1 and block_cnt_o=2; no extra transactions follow.
2. First ready poll returns 0, second returns 2, POLL_WAIT=8 -> exactly 8 idle cycles between the two reads; counters are 0 at the second STB_O.
3. MAX_POLLS=3, done status always 1 -> ERROR after the 3rd failed done-poll; error_o=1, bus idle, block_cnt_o=0.
4. ERR_I on the SIZE write of block 1 (no macro) -> ERROR on the next edge with CYC_O=0 and block_cnt_o=1. With the macro: RTY twice then ACK -> the identical write is reissued twice, the sequence completes, and retry_cnt_o returns to 0.
5. Slave delays ACK by 5 cycles -> STB_O, ADR_O and DAT_O stay stable for all 6 cycles and deassert 1 cycle after ACK_I.
6. RST_I asserted mid-write of block 1 -> outputs return to reset values on the next edge; after release the sequence restarts from block 0 with block_cnt_o=0.
